aes_round_sequencer: RTL

Parametrised control FSM for the iterative AES core. It sequences plaintext load, key load, key expansion and the round transforms, then the ciphertext read. It supports AES-128/192/256 selected at run time, encrypt or decrypt order, a configurable number of datapath beats per transform, and stalls driven by datapath back-pressure. It drives the state-matrix mux/index controls and the round-key index consumed by the key expansion RAM.

---
 rtl/aes_round_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES core: plaintext load, key load/expansion, the round
// transforms in encrypt or decrypt order, and the ciphertext read, with op_ready stalls.
module aes_round_sequencer #(
   parameter int unsigned BEATS_LOG2 = 2,
   parameter int unsigned SEL_W      = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start_write_n,
   input  logic                  start_read_n,
   input  logic                  decrypt,
   input  logic [1:0]            key_len,
   input  logic                  key_expand_done,
   input  logic                  op_ready,
   output logic                  done,
   output logic                  busy,
   output logic                  err,
   output logic                  key_start,
   output logic                  key_wr_en,
   output logic [2:0]            key_wr_idx,
   output logic [3:0]            round_key_idx,
   output logic [SEL_W-1:0]      matrix_in_sel,
   output logic                  matrix_write_enable,
   output logic                  input_mat_row_col,
   output logic [BEATS_LOG2-1:0] input_mat_idx,
   output logic                  output_mat_row_col,
   output logic [BEATS_LOG2-1:0] output_mat_idx,
   output logic [5:0]            dbg_state,
   output logic [3:0]            dbg_round
);

   typedef enum logic [5:0] {
      StIdle       = 6'd0,
      StPtextWrite = 6'd1,
      StKeyWrite   = 6'd2,
      StKeyExpand  = 6'd3,
      StSub        = 6'd4,
      StShift      = 6'd5,
      StMix        = 6'd6,
      StArk        = 6'd7,
      StDoneWait   = 6'd8,
      StCtextRead  = 6'd9,
      StInitArk    = 6'd10
   } state_e;

   localparam logic [BEATS_LOG2-1:0] LastBeat = {BEATS_LOG2{1'b1}};

   state_e                state_q, state_d;
   logic [BEATS_LOG2-1:0] beat_q, beat_d;
   logic [3:0]            round_q, round_d;
   logic [2:0]            kidx_q, kidx_d;
   logic                  dec_q, dec_d;
   logic [1:0]            klen_q, klen_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;

   logic [3:0] nr;
   logic [2:0] nk_last;
   logic       final_round;
   logic       is_xfer;
   logic       beat_last;

   assign nr          = 4'd10 + {1'b0, klen_q, 1'b0};
   assign nk_last     = 3'd3 + {klen_q, 1'b0};
   assign final_round = (round_q == nr - 4'd1);
   assign is_xfer     = state_q inside {StPtextWrite, StInitArk, StSub, StShift, StMix, StArk,
                                        StCtextRead};
   assign beat_last   = is_xfer && op_ready && (beat_q == LastBeat);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      round_d = round_q;
      kidx_d  = kidx_q;
      dec_d   = dec_q;
      klen_d  = klen_q;
      err_d   = err_q;
      done_d  = 1'b0;
      // The beat counter is sized to wrap to 0 exactly at the end of each transform.
      if (is_xfer && op_ready) beat_d = beat_q + 1'b1;
      case (state_q)
         StIdle: begin
            if (!start_write_n) begin
               if (key_len == 2'd3) begin
                  err_d = 1'b1;
               end else begin
                  dec_d   = decrypt;
                  klen_d  = key_len;
                  err_d   = 1'b0;
                  state_d = StPtextWrite;
               end
            end
         end
         StPtextWrite: if (beat_last) state_d = StKeyWrite;
         StKeyWrite: begin
            if (kidx_q == nk_last) begin
               kidx_d  = '0;
               state_d = StKeyExpand;
            end else begin
               kidx_d = kidx_q + 3'd1;
            end
         end
         StKeyExpand: begin
            if (key_expand_done) begin
               round_d = '0;
               state_d = StInitArk;
            end
         end
         StInitArk: if (beat_last) state_d = dec_q ? StShift : StSub;
         StSub:     if (beat_last) state_d = dec_q ? StArk : StShift;
         StShift: begin
            if (beat_last) state_d = dec_q ? StSub : (final_round ? StArk : StMix);
         end
         StMix: begin
            if (beat_last) begin
               if (dec_q) begin
                  round_d = round_q + 4'd1;
                  state_d = StShift;
               end else begin
                  state_d = StArk;
               end
            end
         end
         StArk: begin
            if (beat_last) begin
               if (final_round) begin
                  state_d = StDoneWait;
                  done_d  = 1'b1;
               end else if (dec_q) begin
                  state_d = StMix;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = StSub;
               end
            end
         end
         StDoneWait: if (!start_read_n) state_d = StCtextRead;
         StCtextRead: begin
            if (beat_last) begin
               round_d = '0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            beat_d  = '0;
            round_d = '0;
            kidx_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         beat_q  <= '0;
         round_q <= '0;
         kidx_q  <= '0;
         dec_q   <= 1'b0;
         klen_q  <= 2'd0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         round_q <= round_d;
         kidx_q  <= kidx_d;
         dec_q   <= dec_d;
         klen_q  <= klen_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      key_start           = 1'b0;
      key_wr_en           = 1'b0;
      key_wr_idx          = '0;
      round_key_idx       = '0;
      matrix_in_sel       = '0;
      matrix_write_enable = 1'b0;
      input_mat_row_col   = 1'b0;
      input_mat_idx       = '0;
      output_mat_row_col  = 1'b0;
      output_mat_idx      = '0;
      case (state_q)
         StPtextWrite: begin
            matrix_write_enable = op_ready;
            input_mat_row_col   = 1'b1;
            input_mat_idx       = beat_q;
            key_start           = beat_last;
         end
         StKeyWrite: begin
            key_wr_en  = 1'b1;
            key_wr_idx = kidx_q;
         end
         StInitArk, StSub, StShift, StMix, StArk: begin
            // In-place transform: read and write the same slice; only ShiftRows walks rows.
            matrix_write_enable = op_ready;
            input_mat_row_col   = (state_q != StShift);
            output_mat_row_col  = (state_q != StShift);
            input_mat_idx       = beat_q;
            output_mat_idx      = beat_q;
            case (state_q)
               StSub:     matrix_in_sel = dec_q ? SEL_W'(5) : SEL_W'(1);
               StShift:   matrix_in_sel = dec_q ? SEL_W'(6) : SEL_W'(2);
               StMix:     matrix_in_sel = dec_q ? SEL_W'(7) : SEL_W'(3);
               StInitArk: begin
                  matrix_in_sel = SEL_W'(4);
                  round_key_idx = dec_q ? nr : 4'd0;
               end
               default: begin
                  matrix_in_sel = SEL_W'(4);
                  round_key_idx = dec_q ? (nr - 4'd1 - round_q) : (round_q + 4'd1);
               end
            endcase
         end
         StCtextRead: begin
            output_mat_row_col = 1'b1;
            output_mat_idx     = beat_q;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != StIdle) && (state_q != StDoneWait);
   assign done      = done_q;
   assign err       = err_q;
   assign dbg_state = state_q;
   assign dbg_round = round_q;

endmodule
